// File: rtl/edward_pkg.sv
// Shared constants for the Ed25519 mod-l arithmetic stages.
// The group order l is the Montgomery modulus used by every REDC stage.
package edward_pkg;

  localparam int R_WIDTH = 256;
  localparam logic [R_WIDTH-1:0] ED_L =
    256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;
  localparam int EDWARD_NM_M_LAT = 3;

endpackage

// File: rtl/edward_cond_sub.sv
// Registered conditional subtraction: o_r = hi >= MODULUS ? hi - MODULUS : hi.
// Correct only for hi < 2*MODULUS; updates only when i_en is high.
module edward_cond_sub
  import edward_pkg::*;
#(
  parameter int           W       = R_WIDTH,
  parameter logic [W-1:0] MODULUS = ED_L
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W:0]   i_hi,
  output logic [W-1:0] o_r
);

  logic [W+1:0] w_d;
  logic [W-1:0] r_r;

  // Two extra bits so the sign of hi - MODULUS is the top bit.
  assign w_d = {1'b0, i_hi} - {2'b00, MODULUS};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_r <= '0;
    end else if (i_en) begin
      r_r <= w_d[W+1] ? i_hi[W-1:0] : w_d[W-1:0];
    end
  end

  assign o_r = r_r;

endmodule

// File: rtl/edward_mont_redc_final.sv
// Final Montgomery REDC stage: r = (T + m*N) / R, conditionally reduced below N.
// T is delayed to meet the m*N product from edward_NM_M; misalignment is sticky.
module edward_mont_redc_final
  import edward_pkg::*;
#(
  parameter int                 R_WIDTH = edward_pkg::R_WIDTH,
  parameter int                 MUL_LAT = edward_pkg::EDWARD_NM_M_LAT,
  parameter logic [R_WIDTH-1:0] MODULUS = edward_pkg::ED_L
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_T_vld,
  input  logic [2*R_WIDTH-1:0] i_T,
  input  logic                 i_t_vld,
  input  logic [2*R_WIDTH-1:0] i_t,
  output logic                 o_vld,
  output logic [R_WIDTH-1:0]   o_r,
  output logic                 o_lo_err,
  output logic                 o_align_err
);

  logic                 w_tail_vld;
  logic [2*R_WIDTH-1:0] w_tail_T;
  logic [2*R_WIDTH:0]   w_sum;
  logic                 w_pair;

  logic [R_WIDTH:0]     r_hi;
  logic                 r_lo_nz;
  logic                 r_a_vld;
  logic                 r_align_err;
  logic                 r_vld;
  logic                 r_lo_err;

  // Free-running delay line: the tail holds the T launched MUL_LAT cycles ago.
  for (genvar g = 0; g < MUL_LAT; g++) begin : g_dl
    logic                 r_vld_s;
    logic [2*R_WIDTH-1:0] r_T_s;
    if (g == 0) begin : g_head
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_vld_s <= 1'b0;
          r_T_s   <= '0;
        end else begin
          r_vld_s <= i_T_vld;
          r_T_s   <= i_T;
        end
      end
    end else begin : g_body
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_vld_s <= 1'b0;
          r_T_s   <= '0;
        end else begin
          r_vld_s <= g_dl[g-1].r_vld_s;
          r_T_s   <= g_dl[g-1].r_T_s;
        end
      end
    end
  end

  assign w_tail_vld = g_dl[MUL_LAT-1].r_vld_s;
  assign w_tail_T   = g_dl[MUL_LAT-1].r_T_s;
  assign w_sum      = {1'b0, w_tail_T} + {1'b0, i_t};
  assign w_pair     = i_t_vld & w_tail_vld;

  // Stage A captures only matched pairs; an orphan on either side is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi        <= '0;
      r_lo_nz     <= 1'b0;
      r_a_vld     <= 1'b0;
      r_align_err <= 1'b0;
      r_vld       <= 1'b0;
      r_lo_err    <= 1'b0;
    end else begin
      r_a_vld  <= w_pair;
      r_vld    <= r_a_vld;
      r_lo_err <= r_a_vld & r_lo_nz;
      if (w_pair) begin
        r_hi    <= w_sum[2*R_WIDTH:R_WIDTH];
        r_lo_nz <= |w_sum[R_WIDTH-1:0];
      end
      if (i_t_vld ^ w_tail_vld) begin
        r_align_err <= 1'b1;
      end
    end
  end

  edward_cond_sub #(
    .W       (R_WIDTH),
    .MODULUS (MODULUS)
  ) u_cond_sub (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (r_a_vld),
    .i_hi    (r_hi),
    .o_r     (o_r)
  );

  assign o_vld       = r_vld;
  assign o_lo_err    = r_lo_err;
  assign o_align_err = r_align_err;

endmodule

// File: tb/tb_edward_mont_redc_final.sv
// Self-checking bench for edward_mont_redc_final: directed REDC cases, alignment,
// reset flush, and randomized streams checked against an arithmetic REDC model.
module tb_edward_mont_redc_final;

  localparam int RW  = 256;
  localparam int LAT = 3;
  localparam logic [RW-1:0] NMOD =
    256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;
  localparam int NVEC = 400;

  logic            i_clk;
  logic            i_rst_n;
  logic            i_T_vld;
  logic [2*RW-1:0] i_T;
  logic            i_t_vld;
  logic [2*RW-1:0] i_t;
  logic            o_vld;
  logic [RW-1:0]   o_r;
  logic            o_lo_err;
  logic            o_align_err;

  int compared;
  int mismatched;

  logic [RW-1:0] expR[$];
  logic          expLo[$];

  logic [2*RW-1:0] vecT [NVEC];
  logic [2*RW-1:0] vecM [NVEC];
  logic            vecLaunch [NVEC];

  edward_mont_redc_final dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_T_vld     (i_T_vld),
    .i_T         (i_T),
    .i_t_vld     (i_t_vld),
    .i_t         (i_t),
    .o_vld       (o_vld),
    .o_r         (o_r),
    .o_lo_err    (o_lo_err),
    .o_align_err (o_align_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [2*RW-1:0] obs,
                             input logic [2*RW-1:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Plain REDC arithmetic: sum = T + t, hi = sum / R, result = hi mod N.
  function automatic logic [RW:0] refRedc(input logic [2*RW-1:0] T,
                                          input logic [2*RW-1:0] t);
    logic [2*RW:0] sum;
    logic [RW:0]   hi;
    logic [RW:0]   r;
    logic          lo;
    sum = {1'b0, T} + {1'b0, t};
    hi  = sum[2*RW:RW];
    r   = hi % {1'b0, NMOD};
    lo  = (sum[RW-1:0] != '0);
    return {lo, r[RW-1:0]};
  endfunction

  function automatic logic [RW-1:0] rand256();
    logic [RW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Every output pulse is matched against the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_vld) begin
        if (expR.size() == 0) begin
          checkOutput("unexpected_vld", 1, 0);
        end else begin
          checkOutput("o_r", o_r, expR.pop_front());
          checkOutput("o_lo_err", o_lo_err, expLo.pop_front());
        end
      end else if (o_lo_err) begin
        checkOutput("lo_err_without_vld", o_lo_err, 0);
      end
    end
  end

  task automatic doReset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    i_T_vld = 1'b0;
    i_t_vld = 1'b0;
    expR.delete();
    expLo.delete();
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input string tag, input logic [2*RW-1:0] T,
                               input logic [2*RW-1:0] t, input logic [RW-1:0] r,
                               input logic lo);
    int lat;
    @(posedge i_clk); #1;
    i_T_vld = 1'b1; i_T = T;
    @(posedge i_clk); #1;
    i_T_vld = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; end
    i_t_vld = 1'b1; i_t = t;
    expR.push_back(r);
    expLo.push_back(lo);
    @(posedge i_clk); #1;
    i_t_vld = 1'b0;
    lat = 4;
    for (int i = 0; i < 8; i++) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
      if (o_vld) break;
    end
    checkOutput({tag, "_latency"}, lat, 5);
  endtask

  // Stream vectors with optional bubbles; i_t follows each T by LAT cycles.
  task automatic runStream(input int n, input bit bubbles, input bit resetInFlight);
    for (int i = 0; i < n; i++) begin
      logic [RW-1:0] h;
      logic [RW-1:0] l;
      h = rand256() % NMOD;
      vecM[i] = {{RW{1'b0}}, rand256()} * {{RW{1'b0}}, NMOD};
      l = ($urandom_range(0, 1) == 1) ? (~vecM[i][RW-1:0]) + 1'b1 : rand256();
      vecT[i] = {h, l};
      vecLaunch[i] = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    for (int c = 0; c < n + LAT; c++) begin
      @(posedge i_clk); #1;
      i_T_vld = (c < n) ? vecLaunch[c] : 1'b0;
      if (c < n) i_T = vecT[c];
      i_t_vld = 1'b0;
      if (c >= LAT && vecLaunch[c-LAT]) begin
        logic [RW:0] e;
        i_t_vld = 1'b1;
        i_t = vecM[c-LAT];
        e = refRedc(vecT[c-LAT], vecM[c-LAT]);
        expR.push_back(e[RW-1:0]);
        expLo.push_back(e[RW]);
      end
    end
    if (resetInFlight) begin
      #2;
      i_rst_n = 1'b0;
      i_T_vld = 1'b0;
      i_t_vld = 1'b0;
      expR.delete();
      expLo.delete();
      #1;
      checkOutput("rst_o_vld", o_vld, 0);
      checkOutput("rst_o_r", o_r, 0);
      checkOutput("rst_o_lo_err", o_lo_err, 0);
      repeat (3) @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      repeat (10) @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("post_rst_o_r", o_r, 0);
    end else begin
      @(posedge i_clk); #1;
      i_t_vld = 1'b0;
      repeat (6) @(posedge i_clk);
      @(negedge i_clk);
    end
    checkOutput("queue_drained", expR.size(), 0);
    checkOutput("stream_align", o_align_err, 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    i_rst_n = 1'b0;
    i_T_vld = 1'b0;
    i_t_vld = 1'b0;
    i_T     = '0;
    i_t     = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("reset_o_vld", o_vld, 0);
    checkOutput("reset_o_r", o_r, 0);
    checkOutput("reset_o_lo_err", o_lo_err, 0);
    checkOutput("reset_o_align_err", o_align_err, 0);
    #1 i_rst_n = 1'b1;

    applyStimulus("hi5", {256'd5, 256'd0}, '0, 256'd5, 1'b0);
    applyStimulus("sub_taken", {NMOD + 256'd3, 256'd0}, '0, 256'd3, 1'b0);
    applyStimulus("carry", {256'd0, {256{1'b1}}}, 512'd1, 256'd1, 1'b0);
    applyStimulus("lo_nz", 512'd1, '0, 256'd0, 1'b1);
    checkOutput("directed_align", o_align_err, 0);

    // Orphan product: align error must appear and stick with no result.
    @(posedge i_clk); #1;
    i_t_vld = 1'b1; i_t = 512'd7;
    @(posedge i_clk); #1;
    i_t_vld = 1'b0;
    @(negedge i_clk);
    checkOutput("orphan_t_align", o_align_err, 1);
    repeat (6) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("orphan_t_sticky", o_align_err, 1);
    doReset();
    @(negedge i_clk);
    checkOutput("align_cleared", o_align_err, 0);

    // Orphan T: tail valid without a product also flags misalignment.
    @(posedge i_clk); #1;
    i_T_vld = 1'b1; i_T = {256'd9, 256'd0};
    @(posedge i_clk); #1;
    i_T_vld = 1'b0;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("orphan_T_align", o_align_err, 1);
    doReset();

    runStream(8, 1'b0, 1'b1);
    runStream(NVEC, 1'b0, 1'b0);
    runStream(NVEC, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
